dds_sweep_controller: RTL and testbench
=======================================

# dds_sweep_controller

Sequencer that drives the phase-increment (tuning word) input of the DDS phase accumulator to produce a frequency sweep. It steps the tuning word from a start value to a stop value, holding each word for a programmable dwell time. It also gates the accumulator and clears its phase at the start of each sweep. The block sits between the register/config interface and the phase accumulator, and replaces the fixed increment constant with a run-time schedule.

## Interface
- PHASE_W, 10: width of tuning word and accumulator phase
- DWELL_W, 16: width of dwell counter
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state and outputs
- start  in  1  pulse; begins a sweep when idle
- abort  in  1  pulse; stops any sweep immediately
- cfg_start_inc  in  PHASE_W  first tuning word
- cfg_stop_inc  in  PHASE_W  final (peak) tuning word
- cfg_step  in  PHASE_W  increment between words
- cfg_dwell  in  DWELL_W  each word is held cfg_dwell+1 cycles
- cfg_continuous  in  1  restart the sweep automatically at its end
- cfg_bidir  in  1  up-down sweep (only with SWEEP_BIDIR_EN)
- phase_inc  out  PHASE_W  tuning word to accumulator, registered
- phase_clear  out  1  one-cycle accumulator phase clear
- acc_enable  out  1  accumulator advance enable
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion

## Operation
- All outputs are registered. Reset values: phase_inc=0, phase_clear=0, acc_enable=0, busy=0, done=0. The FSM resets to IDLE.
- FSM states: IDLE, LOAD, DWELL, DONE.
- IDLE: when start=1, capture all cfg_* into shadow registers and go to LOAD. Config changes during a sweep have no effect until the next start.
- LOAD: phase_inc<=start, phase_clear<=1, acc_enable<=1, dwell_cnt<=dwell, dir<=up; go to DWELL.
- DWELL: phase_clear<=0. Decrement dwell_cnt each cycle. On the dwell_cnt==0 cycle, evaluate the end of the word:
  - Up, phase_inc>=stop: sweep ends. If bidir, set dir<=down and step down instead. Otherwise go to LOAD if continuous, else DONE.
  - Up, otherwise: phase_inc<=min(phase_inc+step, stop). Compute the sum in PHASE_W+1 bits so it never wraps. Reload dwell_cnt.
  - Down (bidir only), phase_inc<=start: sweep ends; go to LOAD if continuous, else DONE.
  - Down, otherwise: phase_inc<=max(phase_inc-step, start). Compute with borrow; on underflow, clamp to start.
- DONE: done<=1, acc_enable<=0, busy<=0 next cycle, return to IDLE. phase_inc holds its last word.
- Degenerate configurations:
  - step==0: the first word is held dwell+1 cycles, then the sweep ends.
  - start>=stop: only the start word is presented.
- abort: from any state, go to IDLE next cycle. acc_enable=0, busy=0, no done pulse, phase_inc holds.
- Priority: reset > abort > start. start while busy is ignored.

## Timing
- start sampled in cycle 0. busy=1 from cycle 1. phase_inc=start_inc, phase_clear=1 and acc_enable=1 in cycle 2.
- Each word is visible for exactly cfg_dwell+1 cycles. Word updates are back-to-back with no gap cycle.
- Continuous restart adds one LOAD cycle. During that cycle the old word is held, so the final word is visible for dwell+2 cycles. phase_clear pulses again with the new start word.
- done is asserted on the cycle after the last word's final dwell cycle. busy falls one cycle later.

## Configuration
- SWEEP_BIDIR_EN defined: cfg_bidir=1 selects triangular sweep (start up to stop, then back down to start). Stop is presented once at the peak and start once at the return. With continuous=1, the sweep repeats as a triangle.
- Not defined: cfg_bidir is ignored, the dir register and down-step logic are not built, and every sweep is sawtooth (up only).

## Structure
- Shared package dds_pkg: the state enum, the sweep-direction type, and the default PHASE_W/DWELL_W constants also used by the phase accumulator.
- One sub-module, dds_dwell_timer: loadable down-counter with a zero flag, DWELL_W wide.
- The FSM and tuning-word arithmetic stay in the top module.

## Test plan
- Reset mid-sweep: reset=1 at any state -> next cycle all outputs 0, FSM idle; a subsequent start works normally.
- start=64, stop=256, step=64, dwell=3, single: words 64/128/192/256 each in 4 consecutive cycles (cycles 2-17), phase_clear only in cycle 2, done in cycle 18, busy low in cycle 19.
- start=100, stop=250, step=64: words 100, 164, 228, 250 (clamped, no wrap); then done.
- continuous=1, start=0, stop=128, step=128, dwell=0: pattern 0, 128, 128 (LOAD cycle), 0 ... repeating, with phase_clear on each 0. abort -> acc_enable=0 and busy=0 next cycle, no done.
- Edge configs: step=0 -> single word held dwell+1 cycles, then done. start=300, stop=200 -> only 300 presented. start asserted while busy -> no effect.
- SWEEP_BIDIR_EN, bidir=1, start=0, stop=192, step=64, dwell=1: 0, 64, 128, 192, 128, 64, 0, each 2 cycles, then done.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared DDS types and default widths.
// Used by the sweep controller and the phase accumulator.
package dds_pkg;

  localparam int PHASE_W_DEF = 10;
  localparam int DWELL_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DWELL,
    DONE
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter with zero flag.
// Holds at zero until reloaded.
module dds_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dds_sweep_controller.sv
// DDS tuning-word sweep sequencer.
// Define SWEEP_BIDIR_EN to build the up-down (triangle) sweep.
module dds_sweep_controller
  import dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] cfg_start_inc,
  input  logic [PHASE_W-1:0] cfg_stop_inc,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_continuous,
  input  logic               cfg_bidir,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               phase_clear,
  output logic               acc_enable,
  output logic               busy,
  output logic               done
);

  state_t state;

  logic [PHASE_W-1:0] sh_start;
  logic [PHASE_W-1:0] sh_stop;
  logic [PHASE_W-1:0] sh_step;
  logic [DWELL_W-1:0] sh_dwell;
  logic               sh_cont;

  logic tmr_load;
  logic tmr_zero;

  logic [PHASE_W:0]   up_sum;
  logic [PHASE_W-1:0] up_next;
  logic               at_peak;
  logic               word_end;
  logic [PHASE_W-1:0] nxt_inc;

`ifdef SWEEP_BIDIR_EN
  logic               sh_bidir;
  dir_t               dir;
  dir_t               nxt_dir;
  logic [PHASE_W:0]   dn_diff;
  logic [PHASE_W-1:0] dn_next;
`else
  logic               unused_bidir;
  assign unused_bidir = cfg_bidir;
`endif

  assign tmr_load = (state == LOAD) ||
                    (state == DWELL && tmr_zero);

  dds_dwell_timer #(
    .W(DWELL_W)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .load (tmr_load),
    .value(sh_dwell),
    .zero (tmr_zero)
  );

  // Extra MSB keeps the sum from wrapping past stop.
  always_comb begin
    up_sum  = {1'b0, phase_inc} + {1'b0, sh_step};
    up_next = (up_sum >= {1'b0, sh_stop}) ?
              sh_stop : up_sum[PHASE_W-1:0];
    at_peak = (phase_inc >= sh_stop) ||
              (sh_step == '0);
  end

`ifdef SWEEP_BIDIR_EN
  always_comb begin
    dn_diff = {1'b0, phase_inc} - {1'b0, sh_step};
    dn_next = (dn_diff[PHASE_W] ||
               dn_diff[PHASE_W-1:0] < sh_start) ?
              sh_start : dn_diff[PHASE_W-1:0];
  end

  // Turn around only when a descent actually exists.
  always_comb begin
    word_end = 1'b0;
    nxt_inc  = phase_inc;
    nxt_dir  = dir;
    if (dir == DIR_DOWN) begin
      if (phase_inc <= sh_start) word_end = 1'b1;
      else nxt_inc = dn_next;
    end else if (at_peak) begin
      if (sh_bidir && sh_step != '0 &&
          phase_inc > sh_start) begin
        nxt_dir = DIR_DOWN;
        nxt_inc = dn_next;
      end else begin
        word_end = 1'b1;
      end
    end else begin
      nxt_inc = up_next;
    end
  end
`else
  always_comb begin
    word_end = at_peak;
    nxt_inc  = at_peak ? phase_inc : up_next;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      phase_inc   <= '0;
      phase_clear <= 1'b0;
      acc_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sh_start    <= '0;
      sh_stop     <= '0;
      sh_step     <= '0;
      sh_dwell    <= '0;
      sh_cont     <= 1'b0;
`ifdef SWEEP_BIDIR_EN
      sh_bidir    <= 1'b0;
      dir         <= DIR_UP;
`endif
    end else if (abort) begin
      state       <= IDLE;
      phase_clear <= 1'b0;
      acc_enable  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_start <= cfg_start_inc;
            sh_stop  <= cfg_stop_inc;
            sh_step  <= cfg_step;
            sh_dwell <= cfg_dwell;
            sh_cont  <= cfg_continuous;
`ifdef SWEEP_BIDIR_EN
            sh_bidir <= cfg_bidir;
`endif
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          phase_inc   <= sh_start;
          phase_clear <= 1'b1;
          acc_enable  <= 1'b1;
`ifdef SWEEP_BIDIR_EN
          dir         <= DIR_UP;
`endif
          state       <= DWELL;
        end
        DWELL: begin
          phase_clear <= 1'b0;
          if (tmr_zero) begin
            if (word_end) begin
              if (sh_cont) begin
                state <= LOAD;
              end else begin
                done       <= 1'b1;
                acc_enable <= 1'b0;
                state      <= DONE;
              end
            end else begin
              phase_inc <= nxt_inc;
`ifdef SWEEP_BIDIR_EN
              dir       <= nxt_dir;
`endif
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Directed bench for dds_sweep_controller.
// Build with SWEEP_BIDIR_EN to cover the triangle sweep.
module tb_dds_sweep_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [9:0]  cfg_start_inc;
  logic [9:0]  cfg_stop_inc;
  logic [9:0]  cfg_step;
  logic [15:0] cfg_dwell;
  logic        cfg_continuous;
  logic        cfg_bidir;
  logic [9:0]  phase_inc;
  logic        phase_clear;
  logic        acc_enable;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  dds_sweep_controller dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .cfg_start_inc (cfg_start_inc),
    .cfg_stop_inc  (cfg_stop_inc),
    .cfg_step      (cfg_step),
    .cfg_dwell     (cfg_dwell),
    .cfg_continuous(cfg_continuous),
    .cfg_bidir     (cfg_bidir),
    .phase_inc     (phase_inc),
    .phase_clear   (phase_clear),
    .acc_enable    (acc_enable),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called in cycle 0; returns in cycle 1.
  task automatic kick(input logic [9:0] s,
                      input logic [9:0] p,
                      input logic [9:0] st,
                      input logic [15:0] d,
                      input logic c,
                      input logic b);
    cfg_start_inc  = s;
    cfg_stop_inc   = p;
    cfg_step       = st;
    cfg_dwell      = d;
    cfg_continuous = c;
    cfg_bidir      = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++;
    if (phase_inc !== 10'd0) begin
      n_err++;
      $display("FAIL rst_inc: got %0d want 0", phase_inc);
    end
    n_cmp++;
    if ({phase_clear, acc_enable, busy, done} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_flags: got %b want 0000",
               {phase_clear, acc_enable, busy, done});
    end
    reset = 1'b0;
    step();
    kick(10'd64, 10'd256, 10'd64, 16'd3, 1'b0, 1'b0);
    step();
    step();
    step();
    n_cmp++;
    if (acc_enable !== 1'b1 || phase_inc !== 10'd64) begin
      n_err++;
      $display("FAIL rst_pre: en %b inc %0d want 1 64",
               acc_enable, phase_inc);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (phase_inc !== 10'd0 ||
        {phase_clear, acc_enable, busy, done} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_mid: inc %0d flags %b want 0 0000",
               phase_inc, {phase_clear, acc_enable, busy, done});
    end
    step();
    step();
    n_cmp++;
    if (busy !== 1'b0 || acc_enable !== 1'b0) begin
      n_err++;
      $display("FAIL rst_idle: busy %b en %b want 0 0",
               busy, acc_enable);
    end
  endtask

  task automatic test_basic();
    logic exp_clr;
    kick(10'd64, 10'd256, 10'd64, 16'd3, 1'b0, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || acc_enable !== 1'b0) begin
      n_err++;
      $display("FAIL basic_c1: busy %b en %b want 1 0",
               busy, acc_enable);
    end
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp_clr = (w == 0 && c == 0);
        n_cmp++;
        if (phase_inc !== 10'(64 * (w + 1)) ||
            phase_clear !== exp_clr ||
            acc_enable !== 1'b1 || done !== 1'b0) begin
          n_err++;
          $display("FAIL basic_w%0d_c%0d: inc %0d clr %b en %b dn %b want %0d %b 1 0",
                   w, c, phase_inc, phase_clear, acc_enable,
                   done, 64 * (w + 1), exp_clr);
        end
      end
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b1 || phase_inc !== 10'd256) begin
      n_err++;
      $display("FAIL basic_done: dn %b busy %b inc %0d want 1 1 256",
               done, busy, phase_inc);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || phase_inc !== 10'd256) begin
      n_err++;
      $display("FAIL basic_end: dn %b busy %b inc %0d want 0 0 256",
               done, busy, phase_inc);
    end
  endtask

  task automatic test_clamp();
    logic [9:0] exp_w [4];
    exp_w = '{10'd100, 10'd164, 10'd228, 10'd250};
    kick(10'd100, 10'd250, 10'd64, 16'd1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if (phase_inc !== exp_w[i/2] || done !== 1'b0) begin
        n_err++;
        $display("FAIL clamp_%0d: inc %0d dn %b want %0d 0",
                 i, phase_inc, done, exp_w[i/2]);
      end
    end
    step();
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL clamp_done: dn %b want 1", done);
    end
    step();
  endtask

  task automatic test_continuous();
    logic [9:0] exp_i;
    logic       exp_c;
    kick(10'd0, 10'd128, 10'd128, 16'd0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step();
      exp_i = (i % 3 == 0) ? 10'd0 : 10'd128;
      exp_c = (i % 3 == 0);
      n_cmp++;
      if (phase_inc !== exp_i || phase_clear !== exp_c ||
          acc_enable !== 1'b1 || busy !== 1'b1 ||
          done !== 1'b0) begin
        n_err++;
        $display("FAIL cont_%0d: inc %0d clr %b en %b busy %b dn %b want %0d %b 1 1 0",
                 i, phase_inc, phase_clear, acc_enable, busy,
                 done, exp_i, exp_c);
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if (acc_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        phase_inc !== 10'd128) begin
      n_err++;
      $display("FAIL abort: en %b busy %b dn %b inc %0d want 0 0 0 128",
               acc_enable, busy, done, phase_inc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 ||
          phase_inc !== 10'd128) begin
        n_err++;
        $display("FAIL abort_hold_%0d: dn %b busy %b inc %0d want 0 0 128",
                 i, done, busy, phase_inc);
      end
    end
  endtask

  task automatic test_step_zero();
    kick(10'd50, 10'd100, 10'd0, 16'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (phase_inc !== 10'd50 || done !== 1'b0) begin
        n_err++;
        $display("FAIL step0_%0d: inc %0d dn %b want 50 0",
                 i, phase_inc, done);
      end
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || phase_inc !== 10'd50) begin
      n_err++;
      $display("FAIL step0_done: dn %b inc %0d want 1 50",
               done, phase_inc);
    end
    step();
  endtask

  task automatic test_start_ge_stop();
    kick(10'd300, 10'd200, 10'd10, 16'd1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (phase_inc !== 10'd300 || done !== 1'b0) begin
        n_err++;
        $display("FAIL geq_%0d: inc %0d dn %b want 300 0",
                 i, phase_inc, done);
      end
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || phase_inc !== 10'd300) begin
      n_err++;
      $display("FAIL geq_done: dn %b inc %0d want 1 300",
               done, phase_inc);
    end
    step();
  endtask

  task automatic test_busy_start();
    logic [9:0] exp_w [3];
    exp_w = '{10'd10, 10'd20, 10'd30};
    kick(10'd10, 10'd30, 10'd10, 16'd1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 1) begin
        cfg_start_inc = 10'd500;
        cfg_stop_inc  = 10'd900;
        cfg_dwell     = 16'd5;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      n_cmp++;
      if (phase_inc !== exp_w[i/2] || done !== 1'b0) begin
        n_err++;
        $display("FAIL busy_st_%0d: inc %0d dn %b want %0d 0",
                 i, phase_inc, done, exp_w[i/2]);
      end
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || phase_inc !== 10'd30) begin
      n_err++;
      $display("FAIL busy_st_done: dn %b inc %0d want 1 30",
               done, phase_inc);
    end
    step();
  endtask

`ifdef SWEEP_BIDIR_EN
  task automatic test_bidir();
    logic [9:0] exp_w [7];
    exp_w = '{10'd0, 10'd64, 10'd128, 10'd192,
              10'd128, 10'd64, 10'd0};
    kick(10'd0, 10'd192, 10'd64, 16'd1, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      step();
      n_cmp++;
      if (phase_inc !== exp_w[i/2] || done !== 1'b0) begin
        n_err++;
        $display("FAIL bidir_%0d: inc %0d dn %b want %0d 0",
                 i, phase_inc, done, exp_w[i/2]);
      end
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || phase_inc !== 10'd0) begin
      n_err++;
      $display("FAIL bidir_done: dn %b inc %0d want 1 0",
               done, phase_inc);
    end
    step();
  endtask
`else
  task automatic test_bidir();
    kick(10'd0, 10'd192, 10'd64, 16'd1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++;
      if (phase_inc !== 10'(64 * (i / 2)) || done !== 1'b0) begin
        n_err++;
        $display("FAIL saw_%0d: inc %0d dn %b want %0d 0",
                 i, phase_inc, done, 64 * (i / 2));
      end
    end
    step();
    n_cmp++;
    if (done !== 1'b1 || phase_inc !== 10'd192) begin
      n_err++;
      $display("FAIL saw_done: dn %b inc %0d want 1 192",
               done, phase_inc);
    end
    step();
  endtask
`endif

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    cfg_start_inc  = '0;
    cfg_stop_inc   = '0;
    cfg_step       = '0;
    cfg_dwell      = '0;
    cfg_continuous = 1'b0;
    cfg_bidir      = 1'b0;
    test_reset();
    test_basic();
    test_clamp();
    test_continuous();
    test_step_zero();
    test_start_ge_stop();
    test_busy_start();
    test_bidir();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
